// File: rtl/grant_event_queue_if.sv
// Bundles the arbiter-facing grant/ack lines and the FIFO head/consumer
// handshake of grant_event_queue. The design block takes the slave side.
interface grant_event_queue_if #(
  parameter int NR    = 4,
  parameter int DW    = 64,
  parameter int DEPTH = 8
);
  localparam int GW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NR-1:0][DW-1:0] req_data;
  logic [GW-1:0]         egnt;
  logic                  eval;
  logic [NR-1:0]         ack;
  logic                  arb_stall;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic [GW-1:0]         out_src;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic [31:0]           acc_cnt;

  modport master (
    output req_data, egnt, eval, out_ready,
    input  ack, arb_stall, out_valid, out_data, out_src, count, acc_cnt
  );

  modport slave (
    input  req_data, egnt, eval, out_ready,
    output ack, arb_stall, out_valid, out_data, out_src, count, acc_cnt
  );
endinterface

// File: rtl/grant_event_queue.sv
// Takes the granted requester's payload into an ordered show-ahead FIFO tagged
// with its source index, and returns a one-hot ack to the winning requester.
module grant_event_queue_lane #(
  parameter int LANE = 0,
  parameter int GW   = 2,
  parameter int DW   = 64
) (
  input  logic [GW-1:0] egnt,
  input  logic          push,
  input  logic [DW-1:0] data,
  output logic          ack,
  output logic [DW-1:0] data_sel
);
  logic hit;

  always_comb begin
    hit      = (egnt == GW'(LANE));
    ack      = push && hit;
    // Non-selected lanes contribute zero so the top can OR-reduce them.
    data_sel = hit ? data : '0;
  end
endmodule

module grant_event_queue #(
  parameter int NR    = 4,
  parameter int DW    = 64,
  parameter int DEPTH = 8,
  parameter int AFULL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  grant_event_queue_if.slave    bus
);
  localparam int GW = (NR > 1) ? $clog2(NR) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [GW-1:0] src;
    logic [DW-1:0] data;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           acc_cnt_q, acc_cnt_d;
  logic                  stall_q, stall_d;

  logic                  full, in_range, push, pop;
  logic [NR-1:0]         lane_ack;
  logic [NR-1:0][DW-1:0] lane_data;
  logic [DW-1:0]         sel_data;
  entry_t                wr_entry;

  assign full     = (count_q == CW'(DEPTH));
  assign in_range = (int'(bus.egnt) < NR);
  // Gating with reset keeps ack low for the whole time reset is held.
  assign push     = bus.eval && in_range && !full && !reset;
  assign pop      = bus.out_valid && bus.out_ready;

  for (genvar i = 0; i < NR; i++) begin : g_lane
    grant_event_queue_lane #(.LANE(i), .GW(GW), .DW(DW)) u_lane (
      .egnt     (bus.egnt),
      .push     (push),
      .data     (bus.req_data[i]),
      .ack      (lane_ack[i]),
      .data_sel (lane_data[i])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NR; i++) sel_data = sel_data | lane_data[i];
    wr_entry.src  = bus.egnt;
    wr_entry.data = sel_data;
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    acc_cnt_d = push ? acc_cnt_q + 32'd1 : acc_cnt_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Registered from next-state occupancy so the stall is valid at cycle start.
    stall_d   = (DEPTH - int'(count_d)) <= AFULL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      acc_cnt_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_cnt_q <= acc_cnt_d;
      stall_q   <= stall_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.ack       = lane_ack;
  assign bus.arb_stall = stall_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q].data;
  assign bus.out_src   = mem_q[rd_ptr_q].src;
  assign bus.count     = count_q;
  assign bus.acc_cnt   = acc_cnt_q;
endmodule

// File: tb/tb_grant_event_queue.sv
// Directed vector table plus hand-written full, reset and wrap sequences
// for grant_event_queue (NR=4, DW=64, DEPTH=8, AFULL=2).
module tb_grant_event_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  grant_event_queue_if #(.NR(4), .DW(64), .DEPTH(8)) bus ();

  grant_event_queue #(.NR(4), .DW(64), .DEPTH(8), .AFULL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ev;
    logic [1:0]  g;
    logic [63:0] d;
    logic        rdy;
    logic [3:0]  ack;
    logic        vld;
    logic [1:0]  src;
    logic [63:0] dat;
    logic [3:0]  cnt;
    logic        stall;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ev, input logic [1:0] g, input logic [63:0] d, input logic rdy);
    for (int i = 0; i < 4; i++) bus.req_data[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    bus.req_data[g] = d;
    bus.egnt        = g;
    bus.eval        = ev;
    bus.out_ready   = rdy;
  endtask

  function automatic vec_t v(input logic ev, input logic [1:0] g, input logic [63:0] d,
                             input logic rdy, input logic [3:0] ack, input logic vld,
                             input logic [1:0] src, input logic [63:0] dat,
                             input logic [3:0] cnt, input logic stall);
    v = '{ev, g, d, rdy, ack, vld, src, dat, cnt, stall};
  endfunction

  logic [65:0] q [$];
  int          pushed;
  logic [3:0]  exp_ack;
  logic        ev_r, rdy_r;
  logic [1:0]  g_r;
  logic [63:0] d_r;

  initial begin
    // single grant, then sticky burst on lane 1, stall at 6, push+pop at count 3
    tbl[0]  = v(1'b0, 2'd0, 64'h0,  1'b0, 4'b0000, 1'b0, 2'd0, 64'h0,  4'd0, 1'b0);
    tbl[1]  = v(1'b1, 2'd2, 64'hA5, 1'b0, 4'b0100, 1'b0, 2'd0, 64'h0,  4'd0, 1'b0);
    tbl[2]  = v(1'b0, 2'd0, 64'h0,  1'b0, 4'b0000, 1'b1, 2'd2, 64'hA5, 4'd1, 1'b0);
    tbl[3]  = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd2, 64'hA5, 4'd1, 1'b0);
    tbl[4]  = v(1'b0, 2'd0, 64'h0,  1'b0, 4'b0000, 1'b0, 2'd0, 64'h0,  4'd0, 1'b0);
    tbl[5]  = v(1'b1, 2'd1, 64'h1,  1'b0, 4'b0010, 1'b0, 2'd0, 64'h0,  4'd0, 1'b0);
    tbl[6]  = v(1'b1, 2'd1, 64'h2,  1'b0, 4'b0010, 1'b1, 2'd1, 64'h1,  4'd1, 1'b0);
    tbl[7]  = v(1'b1, 2'd1, 64'h3,  1'b0, 4'b0010, 1'b1, 2'd1, 64'h1,  4'd2, 1'b0);
    tbl[8]  = v(1'b1, 2'd1, 64'h4,  1'b0, 4'b0010, 1'b1, 2'd1, 64'h1,  4'd3, 1'b0);
    tbl[9]  = v(1'b1, 2'd1, 64'h5,  1'b0, 4'b0010, 1'b1, 2'd1, 64'h1,  4'd4, 1'b0);
    tbl[10] = v(1'b1, 2'd3, 64'h33, 1'b0, 4'b1000, 1'b1, 2'd1, 64'h1,  4'd5, 1'b0);
    tbl[11] = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd1, 64'h1,  4'd6, 1'b1);
    tbl[12] = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd1, 64'h2,  4'd5, 1'b0);
    tbl[13] = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd1, 64'h3,  4'd4, 1'b0);
    tbl[14] = v(1'b1, 2'd0, 64'h77, 1'b1, 4'b0001, 1'b1, 2'd1, 64'h4,  4'd3, 1'b0);
    tbl[15] = v(1'b1, 2'd3, 64'h88, 1'b1, 4'b1000, 1'b1, 2'd1, 64'h5,  4'd3, 1'b0);
    tbl[16] = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd3, 64'h33, 4'd3, 1'b0);
    tbl[17] = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd0, 64'h77, 4'd2, 1'b0);
    tbl[18] = v(1'b0, 2'd0, 64'h0,  1'b1, 4'b0000, 1'b1, 2'd3, 64'h88, 4'd1, 1'b0);
    tbl[19] = v(1'b0, 2'd0, 64'h0,  1'b0, 4'b0000, 1'b0, 2'd0, 64'h0,  4'd0, 1'b0);

    // reset state, with a grant present to show ack is held low
    set_in(1'b1, 2'd1, 64'h55, 1'b0);
    #1;
    chk("rst.ack", 64'(bus.ack), 64'h0);
    chk("rst.valid", 64'(bus.out_valid), 64'h0);
    chk("rst.count", 64'(bus.count), 64'h0);
    chk("rst.stall", 64'(bus.arb_stall), 64'h0);
    chk("rst.acc", 64'(bus.acc_cnt), 64'h0);
    set_in(1'b0, 2'd0, 64'h0, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].ev, tbl[i].g, tbl[i].d, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("v%0d.ack", i), 64'(bus.ack), 64'(tbl[i].ack));
      chk($sformatf("v%0d.valid", i), 64'(bus.out_valid), 64'(tbl[i].vld));
      chk($sformatf("v%0d.count", i), 64'(bus.count), 64'(tbl[i].cnt));
      chk($sformatf("v%0d.stall", i), 64'(bus.arb_stall), 64'(tbl[i].stall));
      if (tbl[i].vld) begin
        chk($sformatf("v%0d.src", i), 64'(bus.out_src), 64'(tbl[i].src));
        chk($sformatf("v%0d.data", i), bus.out_data, tbl[i].dat);
      end
      @(posedge clk); #1;
    end
    chk("tbl.acc", 64'(bus.acc_cnt), 64'd9);

    // full: fill, hold grant, pop while full still blocks, then accept
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 2'd0, 64'h100 + 64'(i), 1'b0);
      @(negedge clk);
      chk($sformatf("fill%0d.ack", i), 64'(bus.ack), 64'b0001);
      @(posedge clk); #1;
    end
    chk("full.count", 64'(bus.count), 64'd8);
    chk("full.stall", 64'(bus.arb_stall), 64'd1);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 2'd2, 64'hBEEF, 1'b0);
      @(negedge clk);
      chk("full.hold_ack", 64'(bus.ack), 64'h0);
      @(posedge clk); #1;
      chk("full.hold_count", 64'(bus.count), 64'd8);
    end
    set_in(1'b1, 2'd2, 64'hBEEF, 1'b1);
    @(negedge clk);
    chk("full.pop_ack", 64'(bus.ack), 64'h0);
    @(posedge clk); #1;
    chk("full.pop_count", 64'(bus.count), 64'd7);
    set_in(1'b1, 2'd2, 64'hBEEF, 1'b0);
    @(negedge clk);
    chk("full.regrant_ack", 64'(bus.ack), 64'b0100);
    @(posedge clk); #1;
    chk("full.refill_count", 64'(bus.count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 2'd0, 64'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("drain%0d.src", i), 64'(bus.out_src), (i < 7) ? 64'd0 : 64'd2);
      chk($sformatf("drain%0d.data", i), bus.out_data, (i < 7) ? 64'h101 + 64'(i) : 64'hBEEF);
      @(posedge clk); #1;
    end
    chk("drain.count", 64'(bus.count), 64'd0);
    chk("drain.acc", 64'(bus.acc_cnt), 64'd18);

    // async reset mid-cycle at count=4
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'd3, 64'h200 + 64'(i), 1'b0);
      @(posedge clk); #1;
    end
    chk("arst.pre_count", 64'(bus.count), 64'd4);
    set_in(1'b1, 2'd1, 64'h300, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", 64'(bus.out_valid), 64'h0);
    chk("arst.count", 64'(bus.count), 64'h0);
    chk("arst.acc", 64'(bus.acc_cnt), 64'h0);
    chk("arst.stall", 64'(bus.arb_stall), 64'h0);
    chk("arst.ack", 64'(bus.ack), 64'h0);
    @(posedge clk); #1;
    chk("arst.hold_count", 64'(bus.count), 64'h0);
    set_in(1'b0, 2'd0, 64'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // wrap: 20 random events against a queue model, random consumer
    pushed = 0;
    for (int cyc = 0; cyc < 2000 && !(pushed == 20 && q.size() == 0); cyc++) begin
      ev_r  = (pushed < 20) && ($urandom_range(0, 3) != 0);
      g_r   = 2'($urandom_range(0, 3));
      d_r   = {$urandom, $urandom};
      rdy_r = 1'($urandom_range(0, 1));
      set_in(ev_r, g_r, d_r, rdy_r);
      @(negedge clk);
      exp_ack = (ev_r && q.size() < 8) ? (4'b0001 << g_r) : 4'b0000;
      chk("wrap.count", 64'(bus.count), 64'(q.size()));
      chk("wrap.valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("wrap.ack", 64'(bus.ack), 64'(exp_ack));
      if (rdy_r && q.size() > 0) begin
        chk("wrap.src", 64'(bus.out_src), 64'(q[0][65:64]));
        chk("wrap.data", bus.out_data, q[0][63:0]);
        void'(q.pop_front());
      end
      if (exp_ack != 4'b0000) begin
        q.push_back({g_r, d_r});
        pushed++;
      end
      @(posedge clk); #1;
    end
    if (!(pushed == 20 && q.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wrap.timeout: pushed %0d left %0d expected 20 and 0", pushed, q.size());
    end
    chk("wrap.acc", 64'(bus.acc_cnt), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
